// File: rtl/inst_encoder.sv
// Streaming MoonCore instruction encoder: packs opcode/rd/rs/imm fields into 16-bit
// words and hands each one, with its program address, to the instruction-RAM loader.
module inst_encoder #(
  parameter int CPU_WIDTH = 16,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [4:0]           s_op,
  input  logic [2:0]           s_rd,
  input  logic [2:0]           s_rs,
  input  logic [7:0]           s_imm,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CPU_WIDTH-1:0] m_inst,
  output logic [ADDR_W-1:0]    m_addr,
  output logic                 full,
  output logic                 err_illegal,
  output logic                 err_range,
  output logic [7:0]           err_cnt
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_ADDI = 5'd7,
    OP_SUBI = 5'd8,  OP_SLLI = 5'd9,  OP_SRLI = 5'd10, OP_LI   = 5'd11,
    OP_BEQ  = 5'd12, OP_BLE  = 5'd13, OP_SW   = 5'd14, OP_LW   = 5'd15
  } opcode_e;

  typedef enum logic {EMPTY, HOLD} state_e;

  state_e               state, state_next;
  logic [ADDR_W-1:0]    word_cnt;
  logic                 is_r, is_i, is_li;
  logic                 legal_op, range_bad, accept, good;
  logic [CPU_WIDTH-1:0] enc;

  always_comb begin
    is_r  = 1'b0;
    is_i  = 1'b0;
    is_li = 1'b0;
    case (s_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL:       is_r  = 1'b1;
      OP_ADDI, OP_SUBI, OP_SLLI, OP_SRLI, OP_SW, OP_LW,
      OP_BEQ, OP_BLE:                                              is_i  = 1'b1;
      OP_LI:                                                       is_li = 1'b1;
      default: ;
    endcase
  end

  assign legal_op  = is_r | is_i | is_li;
  assign range_bad = is_i & (|s_imm[7:5]);
  assign s_ready   = rst_n & ~start & ~full & (~m_valid | m_ready);
  assign accept    = s_valid & s_ready;
  assign good      = accept & legal_op & ~range_bad;
  assign m_valid   = (state == HOLD);

  always_comb begin
    enc = '0;
    if (is_li)     enc = {s_imm, s_rd, s_op};
    else if (is_i) enc = {s_imm[4:0], s_rs, s_rd, s_op};
    else           enc = {5'b0, s_rs, s_rd, s_op};
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (good) state_next = HOLD;
      HOLD:    if (m_ready && !good) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      word_cnt    <= '0;
      m_inst      <= '0;
      m_addr      <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
      err_cnt     <= '0;
    end else if (start) begin
      state       <= EMPTY;
      word_cnt    <= '0;
      m_inst      <= '0;
      m_addr      <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
      err_cnt     <= '0;
    end else begin
      state       <= state_next;
      err_illegal <= accept & ~legal_op;
      err_range   <= accept & legal_op & range_bad;
      if (accept && !good && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (good) begin
        m_inst <= enc;
        m_addr <= word_cnt;
        // Counter parks on the last address; full alone blocks further input.
        if (word_cnt == ADDR_W'(DEPTH - 1)) full <= 1'b1;
        else                                word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: vector table plus scoreboarded word stream, with a DEPTH=4
// instance sharing the same stimulus to exercise the full/no-wrap boundary.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n, start, s_valid, m_ready;
  logic [4:0]  s_op;
  logic [2:0]  s_rd, s_rs;
  logic [7:0]  s_imm;
  logic        s_ready, m_valid, full, err_illegal, err_range;
  logic [15:0] m_inst;
  logic [7:0]  m_addr, err_cnt;
  logic        s_ready4, m_valid4, full4, err_illegal4, err_range4;
  logic [15:0] m_inst4;
  logic [7:0]  m_addr4, err_cnt4;

  int unsigned checks = 0, errors = 0, cyc = 0;
  int unsigned next_addr = 0, exp4 = 0, cnt4 = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  inst_encoder #(.CPU_WIDTH(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_op(s_op), .s_rd(s_rd), .s_rs(s_rs), .s_imm(s_imm), .m_valid(m_valid),
    .m_ready(m_ready), .m_inst(m_inst), .m_addr(m_addr), .full(full),
    .err_illegal(err_illegal), .err_range(err_range), .err_cnt(err_cnt));

  inst_encoder #(.CPU_WIDTH(16), .ADDR_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready4),
    .s_op(s_op), .s_rd(s_rd), .s_rs(s_rs), .s_imm(s_imm), .m_valid(m_valid4),
    .m_ready(m_ready), .m_inst(m_inst4), .m_addr(m_addr4), .full(full4),
    .err_illegal(err_illegal4), .err_range(err_range4), .err_cnt(err_cnt4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Opcode numbering: ADD..SRL=0..6, ADDI..SRLI=7..10, LI=11, BEQ,BLE,SW,LW=12..15.
  function automatic logic [15:0] enc_model(input logic [4:0] op, input logic [2:0] rd,
                                            input logic [2:0] rs, input logic [7:0] imm);
    if (op == 5'd11) return {imm, rd, op};
    if (op >= 5'd7)  return {imm[4:0], rs, rd, op};
    return {5'd0, rs, rd, op};
  endfunction

  always @(negedge clk) begin
    if (!rst_n || start) sb.delete();
    else if (m_valid && m_ready) begin
      if (sb.size() == 0) chk("spurious_word", sb.size(), 1);
      else begin
        logic [23:0] e;
        e = sb.pop_front();
        chk("word_inst", m_inst, e[23:8]);
        chk("word_addr", m_addr, e[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n || start) begin
      exp4 = 0;
      cnt4 = 0;
    end else if (m_valid4 && m_ready) begin
      chk("d4_addr", m_addr4, exp4);
      exp4++;
      cnt4++;
    end
  end

  task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [7:0] imm, input logic legal, input logic [15:0] inst);
    int unsigned n = 0;
    s_valid = 1'b1; s_op = op; s_rd = rd; s_rs = rs; s_imm = imm;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("handshake_timeout", s_ready, 1);
    else if (legal) begin
      sb.push_back({inst, 8'(next_addr)});
      next_addr++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    next_addr = 0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  typedef struct {
    logic [4:0] op; logic [2:0] rd; logic [2:0] rs; logic [7:0] imm;
    logic [15:0] inst; logic ill; logic rng;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int unsigned nerr = 0, a0, c0;
    tbl[0]  = '{5'd8,  3'd1, 3'd1, 8'd32,  16'h0000, 1'b0, 1'b1};
    tbl[1]  = '{5'd7,  3'd3, 3'd2, 8'd5,   16'h2A67, 1'b0, 1'b0};
    tbl[2]  = '{5'd11, 3'd7, 3'd0, 8'hA5,  16'hA5EB, 1'b0, 1'b0};
    tbl[3]  = '{5'd0,  3'd1, 3'd4, 8'hFF,  16'h0420, 1'b0, 1'b0};
    tbl[4]  = '{5'd8,  3'd0, 3'd7, 8'd31,  16'hFF08, 1'b0, 1'b0};
    tbl[5]  = '{5'd20, 3'd2, 3'd2, 8'd200, 16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{5'd13, 3'd5, 3'd6, 8'd0,   16'h06AD, 1'b0, 1'b0};
    tbl[7]  = '{5'd15, 3'd2, 3'd1, 8'd17,  16'h894F, 1'b0, 1'b0};
    tbl[8]  = '{5'd6,  3'd7, 3'd7, 8'd0,   16'h07E6, 1'b0, 1'b0};
    tbl[9]  = '{5'd11, 3'd0, 3'd5, 8'hFF,  16'hFF0B, 1'b0, 1'b0};
    tbl[10] = '{5'd14, 3'd1, 3'd2, 8'd255, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{5'd31, 3'd0, 3'd0, 8'd0,   16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    s_op = '0; s_rd = '0; s_rs = '0; s_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_inst", m_inst, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_flags", {full, err_illegal, err_range}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    do_start();

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].imm, !(tbl[i].ill || tbl[i].rng), tbl[i].inst);
      chk("vec_err_illegal", err_illegal, tbl[i].ill);
      chk("vec_err_range", err_range, tbl[i].rng);
      chk("vec_latency_valid", m_valid, !(tbl[i].ill || tbl[i].rng));
      if (tbl[i].ill || tbl[i].rng) nerr++;
    end
    chk("table_err_cnt", err_cnt, nerr);
    drain();

    // Stall with a held word, then release into a back-to-back burst.
    m_ready = 1'b0;
    a0 = next_addr;
    send(5'd9, 3'd4, 3'd3, 8'd12, 1'b1, enc_model(5'd9, 3'd4, 3'd3, 8'd12));
    repeat (5) begin
      @(negedge clk);
      chk("stall_s_ready", s_ready, 0);
      chk("stall_m_valid", m_valid, 1);
      chk("stall_m_inst", m_inst, 16'h6389);
      chk("stall_m_addr", m_addr, a0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 16; k++)
      send(5'd10, 3'(k), 3'(k + 1), 8'(k), 1'b1,
           enc_model(5'd10, 3'(k), 3'(k + 1), 8'(k)));
    chk("b2b_cycles", cyc - c0, 16);
    drain();

    // DEPTH=4 instance: six legal inputs, only addresses 0..3 go out.
    do_start();
    for (int k = 0; k < 6; k++)
      send(5'd11, 3'(k), 3'd0, 8'(k * 7), 1'b1, enc_model(5'd11, 3'(k), 3'd0, 8'(k * 7)));
    drain();
    chk("d4_full", full4, 1);
    chk("d4_s_ready", s_ready4, 0);
    chk("d4_word_count", cnt4, 4);
    chk("main_not_full", full, 0);
    do_start();
    chk("d4_full_cleared", full4, 0);
    send(5'd3, 3'd2, 3'd5, 8'd0, 1'b1, enc_model(5'd3, 3'd2, 3'd5, 8'd0));
    chk("d4_restart_valid", m_valid4, 1);
    chk("d4_restart_addr", m_addr4, 0);
    drain();

    // Full image on the 256-deep instance.
    do_start();
    for (int k = 0; k < 256; k++)
      send(5'(k % 7), 3'(k), 3'(k >> 3), 8'(k), 1'b1,
           enc_model(5'(k % 7), 3'(k), 3'(k >> 3), 8'(k)));
    chk("full_set", full, 1);
    chk("full_s_ready", s_ready, 0);
    drain();

    // Saturating error count.
    do_start();
    for (int k = 0; k < 300; k++)
      send(5'(16 + (k % 16)), 3'd0, 3'd0, 8'd0, 1'b0, 16'h0);
    chk("err_cnt_sat", err_cnt, 255);

    // Reset while a word is held.
    m_ready = 1'b0;
    send(5'd12, 3'd1, 3'd2, 8'd3, 1'b1, enc_model(5'd12, 3'd1, 3'd2, 8'd3));
    chk("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_inst", m_inst, 0);
    chk("midrst_m_addr", m_addr, 0);
    chk("midrst_flags", {full, err_illegal, err_range, s_ready}, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    next_addr = 0;
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    send(5'd1, 3'd6, 3'd5, 8'd0, 1'b1, enc_model(5'd1, 3'd6, 3'd5, 8'd0));
    chk("post_rst_addr", m_addr, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
